// File: rtl/rom_fetch_reader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package   : fetch_pkg                                                        |
// | Purpose   : Shared types and constants for the ROM fetch reader.             |
// | Contents  : fetch_state_t FSM encoding, 6502 reset vector addresses,         |
// |             NOP opcode, ROM window membership helper.                        |
// | Revision  : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    STREAM = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;
  localparam logic [7:0]  NOP_OPCODE   = 8'hEA;

  // The ROM occupies the top 2^aw bytes, so every address bit above the
  // ROM address width must be set.
  function automatic logic in_rom_window(input logic [15:0] pc, input int unsigned aw);
    return (pc >> aw) == (16'hFFFF >> aw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_fetch_reader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : rom_fetch_reader_if                                              |
// | Purpose   : Bundles the ROM bus, redirect request and byte stream of the     |
// |             ROM fetch reader.                                                |
// | Signals   : rom_addr/rom_cs/rom_oe/rom_data   - ROM read bus                 |
// |             redirect_valid/redirect_pc        - fetch restart request        |
// |             byte_valid/byte_data/byte_pc/byte_ready - prefetched byte stream |
// |             vector_done/fetch_fault           - status                       |
// | Modports  : master (the reader), slave (ROM + CPU front end side)            |
// | Revision  : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface rom_fetch_reader_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_cs;
  logic                  rom_oe;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  redirect_valid;
  logic [15:0]           redirect_pc;
  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] byte_data;
  logic [15:0]           byte_pc;
  logic                  byte_ready;
  logic                  vector_done;
  logic                  fetch_fault;

  modport master (
    output rom_addr, rom_cs, rom_oe,
    input  rom_data,
    input  redirect_valid, redirect_pc,
    output byte_valid, byte_data, byte_pc,
    input  byte_ready,
    output vector_done, fetch_fault
  );

  modport slave (
    input  rom_addr, rom_cs, rom_oe,
    output rom_data,
    output redirect_valid, redirect_pc,
    input  byte_valid, byte_data, byte_pc,
    output byte_ready,
    input  vector_done, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : prefetch_fifo                                                    |
// | Purpose   : Small synchronous FIFO holding {pc, byte} prefetch entries.      |
// | Ports     : clk, rst     - clock, synchronous active-high reset              |
// |             push_i/data_i - write an entry (ignored when full, no pop)       |
// |             pop_i        - drop the head entry (ignored when empty)          |
// |             flush_i      - discard all entries; takes priority               |
// |             valid_o/head_o - head entry, driven from flops only              |
// |             count_o      - number of stored entries                          |
// | Revision  : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module prefetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push_i && ((count_q < C_DEPTH) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/rom_fetch_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : rom_fetch_reader                                                 |
// | Purpose   : Reads the 6502 reset vector, then streams sequential program     |
// |             bytes from the ROM window into a prefetch FIFO. A redirect       |
// |             flushes the FIFO and restarts fetch at a new PC.                 |
// | Ports     : clk  - clock, rising edge                                        |
// |             rst  - synchronous active-high reset                             |
// |             bus  - rom_fetch_reader_if.master (ROM bus, redirect, byte       |
// |                    stream, vector_done, fetch_fault)                         |
// | Revision  : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module rom_fetch_reader
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  rom_fetch_reader_if.master bus
);
  localparam int ENTRY_W = 16 + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

  fetch_state_t          state_q, state_d;
  logic [15:0]           fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] vec_lo_q, vec_lo_d;
  logic                  vector_done_q, vector_done_d;
  logic                  fetch_fault_q, fetch_fault_d;

  logic                  w_fetch;
  logic                  w_vec_rd;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ENTRY_W-1:0]    w_head;
  logic [CNT_W-1:0]      w_count;

  assign w_pop  = w_valid && bus.byte_ready;
  assign w_room = (w_count < C_DEPTH) || w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= VEC_LO;
      fetch_pc_q    <= '0;
      vec_lo_q      <= '0;
      vector_done_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      vec_lo_q      <= vec_lo_d;
      vector_done_q <= vector_done_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    vec_lo_d      = vec_lo_q;
    vector_done_d = vector_done_q;
    fetch_fault_d = fetch_fault_q;
    w_fetch       = 1'b0;
    w_vec_rd      = 1'b0;
    w_flush       = 1'b0;
    w_addr        = fetch_pc_q[ADDR_WIDTH-1:0];

    case (state_q)
      // Redirects are ignored while the vector is being read.
      VEC_LO: begin
        w_vec_rd = 1'b1;
        w_addr   = RESET_VEC_LO[ADDR_WIDTH-1:0];
        vec_lo_d = bus.rom_data;
        state_d  = VEC_HI;
      end
      VEC_HI: begin
        w_vec_rd      = 1'b1;
        w_addr        = RESET_VEC_HI[ADDR_WIDTH-1:0];
        fetch_pc_d    = 16'({bus.rom_data, vec_lo_q});
        vector_done_d = 1'b1;
        state_d       = STREAM;
      end
      STREAM: begin
        if (bus.redirect_valid) begin
          w_flush       = 1'b1;
          fetch_pc_d    = bus.redirect_pc;
          fetch_fault_d = 1'b0;
        end else if (!in_rom_window(fetch_pc_q, ADDR_WIDTH)) begin
          // Covers both a redirect outside the ROM and the $FFFF wrap.
          state_d       = FAULT;
          fetch_fault_d = 1'b1;
        end else if (w_room) begin
          w_fetch    = 1'b1;
          fetch_pc_d = fetch_pc_q + 16'd1;
        end
      end
      FAULT: begin
        if (bus.redirect_valid) begin
          w_flush       = 1'b1;
          fetch_pc_d    = bus.redirect_pc;
          fetch_fault_d = 1'b0;
          state_d       = STREAM;
        end
      end
      default: state_d = VEC_LO;
    endcase
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_fetch),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .data_i  ({fetch_pc_q, bus.rom_data}),
    .valid_o (w_valid),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // The FSM sits in VEC_LO during reset; the strobes are masked so the ROM
  // is not selected until reset is released.
  assign bus.rom_cs      = !rst && (w_fetch || w_vec_rd);
  assign bus.rom_oe      = !rst && (w_fetch || w_vec_rd);
  assign bus.rom_addr    = rst ? '0 : w_addr;

  assign bus.byte_valid  = w_valid;
  assign bus.byte_pc     = w_head[ENTRY_W-1 -: 16];
  assign bus.byte_data   = w_head[DATA_WIDTH-1:0];
  assign bus.vector_done = vector_done_q;
  assign bus.fetch_fault = fetch_fault_q;

endmodule
`default_nettype wire

// File: doc/rom_fetch_reader.md
# rom_fetch_reader

Bus initiator for the 16 KB program ROM window ($C000-$FFFF). Out of reset it reads the 6502 reset vector at $FFFC/$FFFD. It then streams sequential program bytes into a small prefetch FIFO, tagging each byte with its 16-bit address. A valid/ready port hands the bytes to the CPU front end, and a redirect input flushes the FIFO and restarts fetch at a new PC (jumps, branches, interrupts).

## Interface
- `ADDR_WIDTH`, 14: ROM address width; ROM window is the top 2^ADDR_WIDTH bytes of the 64 KB space.
- `DATA_WIDTH`, 8: ROM data width.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `rom_addr` out ADDR_WIDTH: ROM byte address (low bits of the current fetch address).
- `rom_cs` out 1: ROM chip select.
- `rom_oe` out 1: ROM output enable; always equal to `rom_cs`.
- `rom_data` in DATA_WIDTH: ROM read data; combinational, valid in the same cycle as `rom_cs`/`rom_oe`/`rom_addr`.
- `redirect_valid` in 1: restart fetch at `redirect_pc`.
- `redirect_pc` in 16: new fetch address.
- `byte_valid` out 1: FIFO head is valid.
- `byte_data` out DATA_WIDTH: FIFO head byte.
- `byte_pc` out 16: address of the FIFO head byte.
- `byte_ready` in 1: consumer accepts the head when asserted with `byte_valid`.
- `vector_done` out 1: reset vector has been loaded; stays high until the next `rst`.
- `fetch_fault` out 1: fetch address is outside the ROM window; fetch is halted.

## Operation
- FSM states:
  - VEC_LO: drive $FFFC, capture the low byte, go to VEC_HI.
  - VEC_HI: drive $FFFD, set `fetch_pc` = {data, low}, set `vector_done`, go to STREAM.
  - STREAM: fetch sequential bytes into the FIFO.
  - FAULT: halted; leaves only on redirect.
- ROM mapping: `rom_addr` = `fetch_pc[ADDR_WIDTH-1:0]`.
- In-window test: `fetch_pc[15:ADDR_WIDTH]` all ones.
- STREAM fetch occurs when both hold:
  - there is FIFO room: count < FIFO_DEPTH, or a pop happens in the same cycle;
  - `redirect_valid` is low.
- A fetch asserts `rom_cs`/`rom_oe`, pushes {`fetch_pc`, `rom_data`} into the FIFO, and increments `fetch_pc` modulo 2^16.
- In STREAM, if `fetch_pc` is out of window: go to FAULT with no fetch; `fetch_fault` = 1.
- Wrap $FFFF→$0000 therefore leads to FAULT after the $FFFF byte.
- In FAULT, the FIFO still drains normally.
- `rom_cs` = 0 in every cycle without a fetch or vector read.
- Redirect, in STREAM or FAULT:
  - flush the FIFO (count = 0);
  - `fetch_pc` = `redirect_pc`; clear `fetch_fault`; go to STREAM;
  - no push that cycle.
  - A handshake completing in the same cycle counts as consumed; the flush wins for all other entries.
- Redirect during VEC_LO/VEC_HI is ignored.
- Pop when `byte_valid && byte_ready`; push and pop in the same cycle leave the count unchanged.

## Timing
- Reset values:
  - `rom_cs` = `rom_oe` = 0, `rom_addr` = 0;
  - `byte_valid` = 0, `byte_data` = 0, `byte_pc` = 0;
  - `vector_done` = 0, `fetch_fault` = 0;
  - FIFO empty; state VEC_LO.
- While `rst` is high, all ROM strobes are low.
- Cycle 0 after `rst` falls: VEC_LO. Cycle 1: VEC_HI. Cycle 2: first fetch. Cycle 3: `byte_valid` = 1.
- Throughput: one byte per cycle under continuous `byte_ready`.
- Redirect sampled in cycle N: fetch of `redirect_pc` in cycle N+1; `byte_valid` with that byte in cycle N+2; `byte_valid` = 0 in cycle N+1.
- `byte_*` are registered FIFO outputs with no combinational path from `byte_ready`. The ROM strobes depend combinationally only on state, count, pop and `redirect_valid`.
- `rst` mid-stream: FIFO is discarded and the vector fetch restarts at VEC_LO.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {VEC_LO, VEC_HI, STREAM, FAULT};
  - constants `RESET_VEC_LO` = 16'hFFFC, `RESET_VEC_HI` = 16'hFFFD;
  - `NOP_OPCODE` = 8'hEA.
- Sub-module `prefetch_fifo`: synchronous FIFO, width 16+DATA_WIDTH, depth FIFO_DEPTH, with push, pop, flush, registered head and count. The top level holds the FSM and PC logic.

## Test plan
- Reset vector $C000 (ROM $3FFC=00, $3FFD=C0), `byte_ready` = 1 → addresses $3FFC, $3FFD, then bytes 18/A9/0A/69 with `byte_pc` $C000-$C003 on consecutive cycles from cycle 3.
- Backpressure: hold `byte_ready` = 0 → exactly 4 fetches, then `rom_cs` = 0. Release → count stays 4 with one push per pop; `byte_pc` sequence has no gaps or duplicates.
- Redirect to $C200 in cycle N with full FIFO → `byte_valid` = 0 in N+1; byte 48 ('H') with `byte_pc` $C200 in N+2, then 65 and 6C.
- Redirect to $8000 → `fetch_fault` = 1, no `rom_cs`, `byte_valid` = 0. A later redirect to $C020 clears the fault and delivers A9.
- Redirect to $FFFE → bytes 00 @ $FFFE and F8 @ $FFFF, then `fetch_fault` = 1 with no access at $0000.
- `rst` pulse mid-stream with a non-empty FIFO → `byte_valid` = 0 and `vector_done` = 0 the next cycle; the vector sequence repeats.
